// File: rtl/instr_encoder.sv
// instr_encoder: captures instruction fields, encodes a MIPS word and hands it downstream with valid/ready
module instr_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op_sel,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   input  logic        out_ready,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [7:0]  instr_addr,
   output logic        busy,
   output logic        err,
   output logic        full
);
   typedef enum logic [1:0] {IDLE, ENCODE, VALID} state_t;
   state_t      state_q;
   logic [3:0]  op_q;
   logic [4:0]  rs_q, rt_q, rd_q;
   logic [15:0] imm_q;
   logic [25:0] target_q;
   logic [31:0] instr_q, instr_d;
   logic        op_ok_d;
   logic        instr_valid_q, err_q, full_q;
   logic [7:0]  addr_q;
   // Encode the captured fields; op_ok_d drops for the unused op_sel codes
   always_comb begin
      instr_d = 32'd0;
      op_ok_d = 1'b1;
      case (op_q)
         4'd0:    instr_d = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b100000};
         4'd1:    instr_d = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b100010};
         4'd2:    instr_d = {6'b001000, rs_q, rt_q, imm_q};
         4'd3:    instr_d = {6'b001100, rs_q, rt_q, imm_q};
         4'd4:    instr_d = {6'b100011, rs_q, rt_q, imm_q};
         4'd5:    instr_d = {6'b101011, rs_q, rt_q, imm_q};
         4'd6:    instr_d = {6'b000100, rs_q, rt_q, imm_q};
         4'd7:    instr_d = {6'b000101, rs_q, rt_q, imm_q};
         4'd8:    instr_d = {6'b000010, target_q};
         default: op_ok_d = 1'b0;
      endcase
   end
   // Control FSM with registered outputs; a pending word is dropped on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         op_q          <= 4'd0;
         rs_q          <= 5'd0;
         rt_q          <= 5'd0;
         rd_q          <= 5'd0;
         imm_q         <= 16'd0;
         target_q      <= 26'd0;
         instr_q       <= 32'd0;
         instr_valid_q <= 1'b0;
         addr_q        <= 8'd0;
         err_q         <= 1'b0;
         full_q        <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: if (start && !full_q) begin
               op_q     <= op_sel;
               rs_q     <= rs;
               rt_q     <= rt;
               rd_q     <= rd;
               imm_q    <= imm;
               target_q <= target;
               state_q  <= ENCODE;
            end
            ENCODE: if (op_ok_d) begin
               instr_q       <= instr_d;
               instr_valid_q <= 1'b1;
               state_q       <= VALID;
            end else begin
               err_q   <= 1'b1;
               state_q <= IDLE;
            end
            VALID: if (out_ready) begin
               instr_valid_q <= 1'b0;
               addr_q        <= addr_q + 8'd1;
               full_q        <= full_q | (addr_q == 8'hFF);
               state_q       <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign instr_addr  = addr_q;
   assign busy        = state_q != IDLE;
   assign err         = err_q;
   assign full        = full_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and random transactions checked against an arithmetic encoding model
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        reset, start, out_ready;
   logic [3:0]  op_sel;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [25:0] target;
   logic [31:0] instr;
   logic        instr_valid, busy, err, full;
   logic [7:0]  instr_addr;

   int n_checks = 0;
   int n_fail = 0;
   int exp_addr = 0;
   int n_words = 0;
   logic [31:0] last_instr = 32'd0;

   localparam int unsigned OPC [9] = '{0, 0, 8, 12, 35, 43, 4, 5, 2};

   instr_encoder dut (
      .clk(clk), .reset(reset), .start(start), .op_sel(op_sel),
      .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
      .out_ready(out_ready), .instr(instr), .instr_valid(instr_valid),
      .instr_addr(instr_addr), .busy(busy), .err(err), .full(full)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input int unsigned op, a, b, c, im, tg);
      int unsigned w;
      if (op <= 1)
         w = a * (1 << 21) + b * (1 << 16) + c * (1 << 11) + (op == 0 ? 32 : 34);
      else if (op == 8)
         w = OPC[8] * (1 << 26) + tg;
      else
         w = OPC[op] * (1 << 26) + a * (1 << 21) + b * (1 << 16) + im;
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic txn(input logic [3:0] op, input logic [4:0] a, b, c, input logic [15:0] im,
                      input logic [25:0] tg, input logic [31:0] exp, input int hold);
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_valid", 32'(instr_valid), 0);
      start = 1'b1; op_sel = op; rs = a; rt = b; rd = c; imm = im; target = tg;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("enc_busy", 32'(busy), 1);
      check("enc_valid", 32'(instr_valid), 0);
      check("enc_err", 32'(err), 0);
      start = 1'b1; op_sel = 4'($urandom); rs = 5'($urandom); rt = 5'($urandom);
      rd = 5'($urandom); imm = 16'($urandom); target = 26'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0;
      if (op > 4'd8) begin
         check("bad_err", 32'(err), 1);
         check("bad_busy", 32'(busy), 0);
         check("bad_valid", 32'(instr_valid), 0);
         check("bad_instr", instr, last_instr);
         check("bad_addr", 32'(instr_addr), exp_addr);
         out_ready = 1'b0;
         @(negedge clk);
         check("bad_err_off", 32'(err), 0);
         check("bad_valid2", 32'(instr_valid), 0);
      end else begin
         check("val_valid", 32'(instr_valid), 1);
         check("val_instr", instr, exp);
         check("val_addr", 32'(instr_addr), exp_addr);
         check("val_busy", 32'(busy), 1);
         for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", 32'(instr_valid), 1);
            check("hold_instr", instr, exp);
            check("hold_addr", 32'(instr_addr), exp_addr);
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         exp_addr = (exp_addr + 1) % 256;
         n_words++;
         last_instr = exp;
         check("xfer_valid", 32'(instr_valid), 0);
         check("xfer_addr", 32'(instr_addr), exp_addr);
         check("xfer_instr", instr, exp);
         check("xfer_busy", 32'(busy), 0);
         check("xfer_full", 32'(full), (n_words >= 256) ? 1 : 0);
      end
   endtask

   task automatic rand_txn(input int max_op);
      logic [3:0]  op;
      logic [4:0]  a, b, c;
      logic [15:0] im;
      logic [25:0] tg;
      op = 4'($urandom_range(0, max_op));
      a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
      im = 16'($urandom); tg = 26'($urandom);
      txn(op, a, b, c, im, tg, model(op, a, b, c, im, tg), $urandom_range(0, 2));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; out_ready = 1'b0; op_sel = 4'd0;
      rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0; target = 26'd0;
      @(negedge clk);
      @(negedge clk);
      check("rst_instr", instr, 0);
      check("rst_valid", 32'(instr_valid), 0);
      check("rst_addr", 32'(instr_addr), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'(err), 0);
      check("rst_full", 32'(full), 0);
      reset = 1'b0;
      txn(4'd2, 5'd1, 5'd2, 5'd0, 16'd5, 26'd0, 32'h20220005, 0);
      txn(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h00221820, 4);
      txn(4'd4, 5'd29, 5'd8, 5'd0, 16'hFFFC, 26'd0, 32'h8FA8FFFC, 1);
      txn(4'd8, 5'd7, 5'd9, 5'd4, 16'h1234, 26'h10, 32'h08000010, 0);
      txn(4'd12, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1, 32'd0, 0);
      for (int i = 0; i < 24; i++) rand_txn(15);
      @(negedge clk);
      start = 1'b1; op_sel = 4'd3; rs = 5'd4; rt = 5'd5; imm = 16'h00FF;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", 32'(instr_valid), 1);
      check("pre_rst_instr", instr, 32'h308500FF);
      out_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_addr = 0; n_words = 0; last_instr = 32'd0;
      check("mid_rst_valid", 32'(instr_valid), 0);
      check("mid_rst_addr", 32'(instr_addr), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_instr", instr, 0);
      while (n_words < 256) rand_txn(8);
      check("wrap_addr", 32'(instr_addr), 0);
      check("wrap_full", 32'(full), 1);
      @(negedge clk);
      start = 1'b1; op_sel = 4'd0;
      @(negedge clk);
      start = 1'b0;
      check("full_busy1", 32'(busy), 0);
      @(negedge clk);
      check("full_busy2", 32'(busy), 0);
      check("full_valid", 32'(instr_valid), 0);
      check("full_hold", 32'(full), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("full_clear", 32'(full), 0);
      check("full_clear_addr", 32'(instr_addr), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to encode one instruction from the current field inputs.
REQ-005 op_sel  input  4  operation select: 0 add, 1 sub, 2 addi, 3 andi, 4 lw, 5 sw, 6 beq, 7 bne, 8 j; 9-15 invalid.
REQ-006 rs, rt, rd  input  5 each  register fields.
REQ-007 imm  input  16  immediate or branch offset.
REQ-008 target  input  26  jump target field.
REQ-009 out_ready  input  1  downstream accepts instr this cycle.
REQ-010 instr  output  32  encoded MIPS word.
REQ-011 instr_valid  output  1  instr holds a valid word awaiting acceptance.
REQ-012 instr_addr  output  8  word address for the current or next word.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 err  output  1  one-cycle pulse for an invalid op_sel.
REQ-015 full  output  1  sticky: 256 words have been emitted.

Function
REQ-016 FSM states: IDLE, ENCODE, VALID.
REQ-017 IDLE and start=1 and full=0: capture op_sel, rs, rt, rd, imm, target; go to ENCODE.
REQ-018 IDLE and start=1 and full=1: ignore the request; stay in IDLE.
REQ-019 start in ENCODE or VALID: ignore; captured fields do not change.
REQ-020 ENCODE with valid op: register instr; go to VALID next edge; instr_valid high 2 cycles after the start edge.
REQ-021 ENCODE with invalid op: pulse err for 1 cycle; return to IDLE; instr_valid, instr and instr_addr unchanged.
REQ-022 R-type (add, sub): {6'b000000, rs, rt, rd, 5'b00000, funct}; funct 6'b100000 for add, 6'b100010 for sub.
REQ-023 I-type: {opcode, rs, rt, imm}; opcodes addi 001000, andi 001100, lw 100011, sw 101011, beq 000100, bne 000101.
REQ-024 J-type: {6'b000010, target}; rs, rt, rd and imm are ignored.
REQ-025 VALID: instr_valid=1; instr and instr_addr held stable until out_ready=1.
REQ-026 VALID and out_ready=1: transfer on that edge; instr_addr += 1 (mod 256); go to IDLE; instr_valid low the next cycle.
REQ-027 out_ready=1 outside VALID: no effect.
REQ-028 Transfer at instr_addr=255: instr_addr wraps to 0; full set and held until reset.
REQ-029 instr keeps the last transferred word after transfer, until the next valid ENCODE.
REQ-030 Throughput: at most 1 word per 3 cycles (start, ENCODE, VALID with out_ready=1).

Reset
REQ-031 reset overrides all other inputs in any state, including mid-VALID.
REQ-032 Reset values: state IDLE; instr=0; instr_valid=0; instr_addr=0; busy=0; err=0; full=0.
REQ-033 A word pending in VALID when reset asserts is discarded, not transferred.

Verification
REQ-034 addi, rs=1, rt=2, imm=5, out_ready=1 -> instr=0x20220005 with instr_valid 2 cycles after start; instr_addr 0->1.
REQ-035 add, rs=1, rt=2, rd=3; out_ready low 4 cycles, then high -> instr=0x00221820 held stable for 5 valid cycles; one transfer only.
REQ-036 lw, rs=29, rt=8, imm=0xFFFC -> 0x8FA8FFFC; j, target=0x10 -> 0x08000010; the two words land at consecutive addresses.
REQ-037 op_sel=12 -> err high exactly 1 cycle; instr_valid never asserts; instr_addr unchanged; busy back to 0 after 2 cycles.
REQ-038 256 accepted words -> instr_addr returns to 0 and full=1; a further start is ignored (busy stays 0); reset clears full.
REQ-039 reset asserted while VALID with out_ready=0 -> next cycle instr_valid=0, instr_addr=0, state IDLE; no transfer counted.
